// File: rtl/axi4_lite_regfile_slave_if.sv
// rtl/axi4_lite_regfile_slave_if.sv - AXI4-Lite bus bundle between a master and the register file slave
interface axi4_lite_regfile_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4_lite_regfile_slave.sv
// rtl/axi4_lite_regfile_slave.sv - AXI4-Lite slave terminating into NUM_REGS read/write registers
// Optional AXI4L_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_regfile_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axi4_lite_regfile_slave_if.slave       axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4L_REGFILE_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $error("axi4_lite_regfile_slave: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
        $error("axi4_lite_regfile_slave: NUM_REGS must be 1..256");
    end
    if (ADDR_WIDTH < ADDR_LSB + IDX_W) begin : g_bad_addr_width
        $error("axi4_lite_regfile_slave: ADDR_WIDTH too small");
    end

    logic                  aw_full_q, aw_full_d;
    logic                  aw_oor_q, aw_oor_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [ADDR_WIDTH-1:0] aw_word, ar_word;
    logic                  aw_hit, ar_hit;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic                  unused_prot;

    assign unused_prot = ^{axi.awprot, axi.arprot};

    assign aw_word = axi.awaddr >> ADDR_LSB;
    assign ar_word = axi.araddr >> ADDR_LSB;
    assign aw_hit  = aw_word < ADDR_WIDTH'(NUM_REGS);
    assign ar_hit  = ar_word < ADDR_WIDTH'(NUM_REGS);

    // Readies come from state and rst only, never from the valids.
    assign axi.awready = !aw_full_q && !bvalid_q && !rst;
    assign axi.wready  = !w_full_q && !bvalid_q && !rst;
    assign axi.arready = !rvalid_q && !rst;

    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid && axi.wready;
    assign ar_hs  = axi.arvalid && axi.arready;
    assign commit = aw_full_q && w_full_q;

    always_comb begin
        aw_full_d = aw_full_q;
        aw_oor_d  = aw_oor_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        pulse_d   = '0;
        regs_d    = regs_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_oor_q ? RESP_OOR : RESP_OKAY;
            if (!aw_oor_q) begin
                pulse_d[aw_idx_q] = 1'b1;
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (wstrb_q[b]) begin
                        regs_d[aw_idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
                    end
                end
            end
        end else if (bvalid_q && axi.bready) begin
            bvalid_d = 1'b0;
        end

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_oor_d  = !aw_hit;
            aw_idx_d  = aw_word[IDX_W-1:0];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = axi.wdata;
            wstrb_d  = axi.wstrb;
        end
    end

    // Reads sample regs_q, so a same-cycle commit is not visible yet.
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_hit ? RESP_OKAY : RESP_OOR;
            rdata_d  = ar_hit ? regs_q[ar_word[IDX_W-1:0]] : '0;
        end else if (rvalid_q && axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_q <= 1'b0;
            aw_oor_q  <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            aw_full_q <= aw_full_d;
            aw_oor_q  <= aw_oor_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            regs_q    <= regs_d;
        end
    end

    assign axi.bvalid   = bvalid_q;
    assign axi.bresp    = bresp_q;
    assign axi.rvalid   = rvalid_q;
    assign axi.rresp    = rresp_q;
    assign axi.rdata    = rdata_q;
    assign reg_wr_pulse = pulse_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// tb/tb_axi4_lite_regfile_slave.sv - scoreboard bench for the AXI4-Lite register file slave
module tb_axi4_lite_regfile_slave;
    localparam int NR = 16;
    localparam int VW = NR * 32;
`ifdef AXI4L_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [VW-1:0] reg_q;
    logic [NR-1:0] reg_wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [VW-1:0] exp_q = '0;
    logic [1:0]    b_q [$];
    logic [33:0]   r_q [$];

    axi4_lite_regfile_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_if ();

    axi4_lite_regfile_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .RESET_VAL(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .axi(axi_if),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        merge = old;
        for (int b = 0; b < 4; b++) if (s[b]) merge[b*8 +: 8] = d[b*8 +: 8];
    endfunction

    // Scoreboard monitor: one pop per B or R handshake.
    always @(negedge clk) begin
        if (!rst && axi_if.bvalid && axi_if.bready) begin
            if (b_q.size() == 0) chk("b_unexpected", 1, 0);
            else chk("bresp", axi_if.bresp, b_q.pop_front());
        end
        if (!rst && axi_if.rvalid && axi_if.rready) begin
            if (r_q.size() == 0) chk("r_unexpected", 1, 0);
            else chk("rresp_rdata", {axi_if.rresp, axi_if.rdata}, r_q.pop_front());
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        logic [NR-1:0] ep;
        int idx;
        idx = int'(addr >> 2);
        ep  = (idx < NR) ? (NR'(1) << idx) : '0;
        b_q.push_back(er);
        axi_if.awaddr = addr; axi_if.awvalid = 1'b1;
        axi_if.wdata = d; axi_if.wstrb = s; axi_if.wvalid = 1'b1;
        tick;
        axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
        chk("bvalid_t1", axi_if.bvalid, 0);
        tick;
        chk("bvalid_t2", axi_if.bvalid, 1);
        chk("bresp_t2", axi_if.bresp, er);
        chk("pulse_t2", reg_wr_pulse, ep);
        if (idx < NR) exp_q[idx*32 +: 32] = merge(exp_q[idx*32 +: 32], d, s);
        chk("reg_q_commit", reg_q, exp_q);
        if (axi_if.bready) begin
            tick;
            chk("pulse_clear", reg_wr_pulse, 0);
            chk("bvalid_clear", axi_if.bvalid, 0);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er);
        r_q.push_back({er, ed});
        axi_if.araddr = addr; axi_if.arvalid = 1'b1;
        tick;
        axi_if.arvalid = 1'b0;
        chk("rvalid_t1", axi_if.rvalid, 1);
        chk("rdata_t1", axi_if.rdata, ed);
        tick;
        chk("rvalid_clear", axi_if.rvalid, 0);
    endtask

    initial begin
        axi_if.awaddr = '0; axi_if.awprot = '0; axi_if.awvalid = 1'b0;
        axi_if.wdata = '0; axi_if.wstrb = '0; axi_if.wvalid = 1'b0;
        axi_if.bready = 1'b1;
        axi_if.araddr = '0; axi_if.arprot = '0; axi_if.arvalid = 1'b0;
        axi_if.rready = 1'b1;

        repeat (3) tick;
        chk("rst_readies", {axi_if.awready, axi_if.wready, axi_if.arready}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_readies", {axi_if.awready, axi_if.wready, axi_if.arready}, 3'b111);
        chk("post_rst_valids", {axi_if.bvalid, axi_if.rvalid}, 0);
        chk("post_rst_regs", reg_q, exp_q);
        chk("post_rst_rdata", axi_if.rdata, 0);
        tick;

        // AW and W together, then read back
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read(32'h08, 32'hDEADBEEF, 2'b00);

        // W three cycles ahead of AW, partial strobe
        axi_if.wdata = 32'h11223344; axi_if.wstrb = 4'h5; axi_if.wvalid = 1'b1;
        b_q.push_back(2'b00);
        tick;
        axi_if.wvalid = 1'b0;
        tick;
        chk("w_only_no_b", axi_if.bvalid, 0);
        tick;
        axi_if.awaddr = 32'h04; axi_if.awvalid = 1'b1;
        tick;
        axi_if.awvalid = 1'b0;
        chk("split_bvalid_t1", axi_if.bvalid, 0);
        tick;
        chk("split_bvalid_t2", axi_if.bvalid, 1);
        chk("split_pulse", reg_wr_pulse, 16'h0002);
        exp_q[1*32 +: 32] = 32'h00220044;
        chk("split_reg_q", reg_q, exp_q);
        tick;

        // B backpressure
        axi_if.bready = 1'b0;
        do_write(32'h14, 32'h00000055, 4'hF, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_bvalid", axi_if.bvalid, 1);
            chk("bp_bresp", axi_if.bresp, 0);
            chk("bp_readies", {axi_if.awready, axi_if.wready}, 0);
        end
        axi_if.bready = 1'b1;
        tick;
        chk("bp_readies_back", {axi_if.awready, axi_if.wready}, 2'b11);
        chk("bp_bvalid_clear", axi_if.bvalid, 0);

        // Out-of-range read and write
        do_read(NR * 4, 32'h0, OOR);
        do_write(NR * 4, 32'hFFFFFFFF, 4'hF, OOR);

        // Commit to reg 3 coincides with AR on reg 3
        do_write(32'h0C, 32'h0000000A, 4'hF, 2'b00);
        b_q.push_back(2'b00);
        axi_if.awaddr = 32'h0C; axi_if.awvalid = 1'b1;
        axi_if.wdata = 32'h0000000B; axi_if.wstrb = 4'hF; axi_if.wvalid = 1'b1;
        tick;
        axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
        r_q.push_back({2'b00, 32'h0000000A});
        axi_if.araddr = 32'h0C; axi_if.arvalid = 1'b1;
        tick;
        axi_if.arvalid = 1'b0;
        chk("collide_rdata_old", axi_if.rdata, 32'h0000000A);
        exp_q[3*32 +: 32] = 32'h0000000B;
        chk("collide_reg_q", reg_q, exp_q);
        tick;
        do_read(32'h0C, 32'h0000000B, 2'b00);

        // Reset while bvalid is pending and W is held
        axi_if.bready = 1'b0;
        do_write(32'h1C, 32'h00000077, 4'hF, 2'b00);
        axi_if.wdata = 32'hCAFEF00D; axi_if.wstrb = 4'hF; axi_if.wvalid = 1'b1;
        tick;
        rst = 1'b1;
        b_q.delete();
        exp_q = '0;
        #1;
        chk("mid_rst_bvalid", axi_if.bvalid, 0);
        chk("mid_rst_readies", {axi_if.awready, axi_if.wready, axi_if.arready}, 0);
        chk("mid_rst_pulse", reg_wr_pulse, 0);
        chk("mid_rst_regs", reg_q, exp_q);
        chk("mid_rst_bresp_rdata", {axi_if.bresp, axi_if.rresp, axi_if.rdata}, 0);
        axi_if.wvalid = 1'b0;
        tick;
        rst = 1'b0;
        axi_if.bready = 1'b1;
        #1;
        chk("rel_readies", {axi_if.awready, axi_if.wready, axi_if.arready}, 3'b111);
        axi_if.awaddr = 32'h20; axi_if.awvalid = 1'b1;
        tick;
        axi_if.awvalid = 1'b0;
        tick;
        tick;
        chk("rel_w_slot_empty", axi_if.bvalid, 0);
        b_q.push_back(2'b00);
        axi_if.wdata = 32'h12345678; axi_if.wstrb = 4'hF; axi_if.wvalid = 1'b1;
        tick;
        axi_if.wvalid = 1'b0;
        chk("rel_bvalid_t1", axi_if.bvalid, 0);
        tick;
        chk("rel_bvalid_t2", axi_if.bvalid, 1);
        chk("rel_pulse", reg_wr_pulse, 16'h0100);
        exp_q[8*32 +: 32] = 32'h12345678;
        chk("rel_reg_q", reg_q, exp_q);
        tick;
        tick;

        chk("b_queue_empty", b_q.size(), 0);
        chk("r_queue_empty", r_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
